// File: rtl/pe_tree_accumulator.sv
// pe_tree_accumulator
// Sink-side companion to the pipelined ternary adder tree. A valid/last delay
// line follows each operand set through the tree, successive tree outputs are
// summed into one dot-product result per vector, and finished results wait in
// a small first-word-fall-through FIFO for the PE output stage.
// Optional build macro: PE_ACC_SAT_EN (saturating accumulation instead of
// two's complement wrap).

module pe_tree_accumulator #(
   parameter int TREE_NUM   = 5,
   parameter int IN_SIZE    = 7,
   parameter int ACC_SIZE   = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_last,
   input  logic [IN_SIZE-1:0]  tree_dout,
   output logic [ACC_SIZE-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overflow_err,
   output logic                busy
);

   // Each tree level collapses up to three operands into one, so the depth
   // is the number of divide-by-three steps needed to reach a single node.
   function automatic int tree_lat(input int n);
      int levels;
      int remaining;
      levels    = 1;
      remaining = n;
      while (remaining > 3) begin
         remaining = (remaining + 2) / 3;
         levels    = levels + 1;
      end
      return levels;
   endfunction

   localparam int LAT   = tree_lat(TREE_NUM);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [LAT-1:0]      dl_valid;
   logic [LAT-1:0]      dl_last;
   logic                arr_valid;
   logic                arr_last;

   logic [ACC_SIZE-1:0] acc;
   logic                acc_empty;
   logic [ACC_SIZE-1:0] acc_base;
   logic [ACC_SIZE-1:0] din_ext;
   logic [ACC_SIZE-1:0] acc_next;

   logic [ACC_SIZE-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                push;
   logic                pop;
   logic                full;
   logic                push_ok;

   // Shift the operand-set markers alongside the tree so the tap lines up
   // with tree_dout; a last flag without its valid is discarded on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_valid <= '0;
         dl_last  <= '0;
      end else begin
         dl_valid[0] <= in_valid;
         dl_last[0]  <= in_valid & in_last;
         for (int i = 1; i < LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_last[i]  <= dl_last[i-1];
         end
      end
   end

   assign arr_valid = dl_valid[LAT-1];
   assign arr_last  = dl_last[LAT-1];

   // Running sum including the arriving tree output; an empty accumulator
   // contributes zero so a new vector starts cleanly without an idle cycle.
   always_comb begin
      acc_base = acc_empty ? '0 : acc;
      din_ext  = ACC_SIZE'($signed(tree_dout));
      acc_next = '0;
`ifdef PE_ACC_SAT_EN
      begin : sat_add
         logic [ACC_SIZE:0] wide_sum;
         wide_sum = {acc_base[ACC_SIZE-1], acc_base} + {din_ext[ACC_SIZE-1], din_ext};
         if (wide_sum[ACC_SIZE] != wide_sum[ACC_SIZE-1]) begin
            if (wide_sum[ACC_SIZE]) begin
               acc_next = {1'b1, {(ACC_SIZE-1){1'b0}}};
            end else begin
               acc_next = {1'b0, {(ACC_SIZE-1){1'b1}}};
            end
         end else begin
            acc_next = wide_sum[ACC_SIZE-1:0];
         end
      end
`else
      acc_next = acc_base + din_ext;
`endif
   end

   // Fold arriving tree outputs into the accumulator; the last set of a
   // vector hands its sum to the FIFO and leaves the accumulator empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         acc_empty <= 1'b1;
      end else if (arr_valid) begin
         if (arr_last) begin
            acc       <= '0;
            acc_empty <= 1'b1;
         end else begin
            acc       <= acc_next;
            acc_empty <= 1'b0;
         end
      end
   end

   // A push into a full FIFO only fits if the head leaves in the same cycle.
   always_comb begin
      push    = arr_valid & arr_last;
      pop     = out_valid & out_ready;
      full    = (count == CNT_W'(FIFO_DEPTH));
      push_ok = push & (~full | pop);
   end

   // Result FIFO storage, pointers and occupancy; a refused push is
   // remembered in the sticky overflow flag until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= acc_next;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push && !push_ok) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // Head entry is presented straight from storage, and busy covers every
   // place a vector can still be in progress.
   always_comb begin
      out_data  = mem[rd_ptr];
      out_valid = (count != '0);
      busy      = (|dl_valid) | ~acc_empty | (count != '0);
   end

endmodule

// File: tb/tb_pe_tree_accumulator.sv
// Bench for pe_tree_accumulator: a behavioural stand-in for the adder tree
// feeds tree_dout two cycles after each operand set, expected sums go into a
// queue as vectors are issued, and a monitor pops them as the DUT hands off.
// A second narrow instance exercises the PE_ACC_SAT_EN / wrap behaviour.

module tb_pe_tree_accumulator;

   localparam int TB_LAT = 2;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_last;
   logic        [6:0]  tree_dout;
   logic        [23:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic               overflow_err;
   logic               busy;

   logic               in_valid_s;
   logic               in_last_s;
   logic        [7:0]  out_data_s;
   logic               out_valid_s;
   logic               out_ready_s;
   logic               overflow_err_s;
   logic               busy_s;

   logic signed [6:0]  set_val;
   logic signed [6:0]  tree_pipe [TB_LAT];

   int                 checks;
   int                 errors;
   int                 model_acc;
   int                 exp_q [$];

   pe_tree_accumulator #(
      .TREE_NUM(5), .IN_SIZE(7), .ACC_SIZE(24), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .tree_dout(tree_dout), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .overflow_err(overflow_err), .busy(busy)
   );

   pe_tree_accumulator #(
      .TREE_NUM(5), .IN_SIZE(7), .ACC_SIZE(8), .FIFO_DEPTH(4)
   ) dut_narrow (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_last(in_last_s),
      .tree_dout(tree_dout), .out_data(out_data_s), .out_valid(out_valid_s),
      .out_ready(out_ready_s), .overflow_err(overflow_err_s), .busy(busy_s)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Two-stage stand-in for the adder tree (TREE_NUM=5), without reset.
   always_ff @(posedge clk) begin
      tree_pipe[0] <= set_val;
      tree_pipe[1] <= tree_pipe[0];
   end
   assign tree_dout = tree_pipe[1];

   task automatic check_output(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Every handshake that completes is matched against the oldest expected sum.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("[TB] FAIL unexpected_result: observed %0d expected none",
                      $signed(out_data));
            end
         end else begin
            check_output("result", $signed(out_data), exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand set to the tree; keep=0 marks a result that the
   // full FIFO is known to drop.
   task automatic apply_stimulus(input int v, input bit last, input bit keep);
      in_valid  = 1'b1;
      in_last   = last;
      set_val   = 7'(v);
      model_acc = model_acc + v;
      if (last) begin
         if (keep) exp_q.push_back(model_acc);
         model_acc = 0;
      end
      step();
   endtask

   task automatic release_inputs();
      in_valid = 1'b0;
      in_last  = 1'b0;
      set_val  = '0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst       = 1'b0;
      model_acc = 0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check_output(tag, 32'(done), 32'sd1);
   endtask

   initial begin
      bit got;
      checks      = 0;
      errors      = 0;
      model_acc   = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      set_val     = '0;
      out_ready   = 1'b0;
      in_valid_s  = 1'b0;
      in_last_s   = 1'b0;
      out_ready_s = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;

      // Reset state.
      check_output("rst_out_valid", 32'(out_valid), 0);
      check_output("rst_busy", 32'(busy), 0);
      check_output("rst_overflow", 32'(overflow_err), 0);
      check_output("rst_out_data", $signed(out_data), 0);

      // Latency and sum: 10 - 3 + 7, out_valid exactly 3 cycles after last.
      out_ready = 1'b1;
      apply_stimulus(10, 1'b0, 1'b1);
      apply_stimulus(-3, 1'b0, 1'b1);
      apply_stimulus(7, 1'b1, 1'b1);
      release_inputs();
      check_output("lat_busy", 32'(busy), 1);
      check_output("lat_valid_t1", 32'(out_valid), 0);
      step();
      check_output("lat_valid_t2", 32'(out_valid), 0);
      step();
      check_output("lat_valid_t3", 32'(out_valid), 1);
      check_output("lat_data", $signed(out_data), 14);
      wait_drain("lat_drain", 20);

      // Back-to-back vectors of length 1 and 2.
      apply_stimulus(5, 1'b1, 1'b1);
      apply_stimulus(4, 1'b0, 1'b1);
      apply_stimulus(6, 1'b1, 1'b1);
      release_inputs();
      wait_drain("b2b_drain", 20);

      // Backpressure: six single-set vectors into a four-entry FIFO.
      out_ready = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         apply_stimulus(v, 1'b1, v <= 4);
      end
      release_inputs();
      check_output("ovf_before_fifth", 32'(overflow_err), 0);
      check_output("ovf_full_valid", 32'(out_valid), 1);
      step();
      check_output("ovf_after_fifth", 32'(overflow_err), 1);
      step();
      step();
      check_output("ovf_head", $signed(out_data), 1);
      out_ready = 1'b1;
      wait_drain("ovf_drain", 20);
      check_output("ovf_sticky", 32'(overflow_err), 1);
      check_output("ovf_empty", 32'(out_valid), 0);
      pulse_reset();
      check_output("ovf_cleared", 32'(overflow_err), 0);

      // Full FIFO with a pop in the same cycle as a push.
      out_ready = 1'b0;
      for (int v = 11; v <= 15; v++) begin
         apply_stimulus(v, 1'b1, 1'b1);
      end
      release_inputs();
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_output("fullpop_overflow", 32'(overflow_err), 0);
      check_output("fullpop_head", $signed(out_data), 12);
      out_ready = 1'b1;
      wait_drain("fullpop_drain", 20);
      check_output("fullpop_overflow_end", 32'(overflow_err), 0);

      // Reset while a partial vector is in the tree.
      apply_stimulus(20, 1'b0, 1'b0);
      apply_stimulus(21, 1'b0, 1'b0);
      release_inputs();
      pulse_reset();
      check_output("midrst_busy", 32'(busy), 0);
      check_output("midrst_valid", 32'(out_valid), 0);
      check_output("midrst_data", $signed(out_data), 0);
      step();
      step();
      step();
      check_output("midrst_busy_later", 32'(busy), 0);
      apply_stimulus(9, 1'b1, 1'b1);
      release_inputs();
      wait_drain("midrst_drain", 20);

      // Narrow accumulator: four arrivals of 63 overflow 8 bits.
      for (int i = 0; i < 4; i++) begin
         in_valid_s = 1'b1;
         in_last_s  = (i == 3);
         set_val    = 7'sd63;
         step();
      end
      in_valid_s = 1'b0;
      in_last_s  = 1'b0;
      set_val    = '0;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid_s) begin
            got = 1'b1;
            break;
         end
         step();
      end
      check_output("sat_valid", 32'(got), 1);
`ifdef PE_ACC_SAT_EN
      check_output("sat_result", $signed(out_data_s), 127);
`else
      check_output("wrap_result", $signed(out_data_s), -4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_tree_accumulator.md
Name: pe_tree_accumulator

Overview:
- Sink-side companion to the pipelined ternary adder tree.
- Tracks the tree's fixed pipeline latency with a valid/last delay line.
- Accumulates successive tree outputs into one dot-product result per vector; the tree output has no valid and cannot stall.
- Buffers finished results in a small first-word-fall-through (FWFT) FIFO, drained over a valid/ready handshake toward the PE output stage.

Parameters:
- TREE_NUM, 5, number of tree inputs; sets the tree latency.
- IN_SIZE, 7, width of the tree output (tree OUT_SIZE), signed.
- ACC_SIZE, 24, accumulator and result width, signed; must be >= IN_SIZE.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  high in the cycle an operand set is presented to the tree's din
- in_last  input  1  qualifies in_valid: this set is the final one of the vector
- tree_dout  input  IN_SIZE  tree dout, signed
- out_data  output  ACC_SIZE  head-of-FIFO result
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready
- overflow_err  output  1  sticky: a finished result was dropped
- busy  output  1  anything in flight, partially accumulated or buffered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Latency LAT is computed at elaboration by a constant function:
  - lat(n) = 1 for n <= 3.
  - lat(n) = 1 + lat((n+2)/3) otherwise.
  - Examples: TREE_NUM 2,3 -> 1; 5,9 -> 2; 10 -> 3.
- Delay line: {in_valid, in_last} shifts through LAT registers. Its tap arr_valid/arr_last is aligned with tree_dout for that operand set.
- Accumulate on arr_valid: acc_next = (acc_empty ? 0 : acc) + sign-extended tree_dout.
  - Without arr_last: acc <= acc_next, acc_empty <= 0.
  - With arr_last: push acc_next into the FIFO, acc <= 0, acc_empty <= 1.
  - No arr_valid: acc holds.
- FIFO push/pop:
  - Pop occurs when out_valid && out_ready.
  - Push while full with no pop in the same cycle: result dropped, overflow_err <= 1 until rst.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Push into an empty FIFO: out_valid rises the next cycle. There is no bypass.
- Outputs:
  - out_data is the registered head entry; its value while out_valid=0 is don't-care.
  - out_valid = (count != 0).
  - busy = any delay-line valid || !acc_empty || count != 0.
- Latency: last operand set at cycle t -> out_valid at cycle t+LAT+1.
- Wrap: the FIFO read and write pointers wrap modulo FIFO_DEPTH.
- Reset (including mid-operation):
  - Clears the delay line, acc (0), acc_empty (1), FIFO pointers and count, and overflow_err.
  - Outputs after reset: out_valid=0, busy=0, overflow_err=0, out_data=0.
  - In-flight tree results arriving after reset are ignored because their delay-line valids were cleared. The tree itself has no reset.
- in_valid and in_last are sampled in every cycle rst is low.
- in_last without in_valid is ignored.
- A vector of length 1 (in_valid && in_last) yields a result equal to that single tree output.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined: acc_next is computed one bit wider and clamped to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1]. Saturated values are both stored and pushed.
- Not defined: acc_next wraps two's complement at ACC_SIZE bits, with no extra logic.

Test Plan:
- Latency/sum: TREE_NUM=5 (LAT=2), vector of 3 sets with tree_dout 10, -3, 7 at arrival, out_ready=1 -> single result 14; out_valid rises exactly 3 cycles after the last in_valid.
- Back-to-back vectors: lengths 1 and 2 with arrivals 5 | 4, 6, issued consecutively -> results 5 then 10 in order; the accumulator clears between them with no idle cycle.
- Backpressure/overflow: FIFO_DEPTH=4, out_ready=0, six length-1 vectors of values 1..6 -> FIFO holds 1,2,3,4; overflow_err=1 after the 5th; releasing out_ready drains exactly 1,2,3,4.
- Full with simultaneous pop: FIFO full, out_ready=1 in the cycle a push arrives -> push accepted, overflow_err stays 0, count stays 4.
- Mid-vector reset: 2 of 3 sets issued, rst pulsed for 1 cycle while results are in flight -> no result emitted, busy=0; a following length-1 vector of value 9 produces 9.
- Saturation: ACC_SIZE=8, IN_SIZE=7, four arrivals of 63 -> with PE_ACC_SAT_EN result 127; without it, result -4 (252 wrapped).
